// File: rtl/otter_mem_pkg.sv
// otter_mem_pkg: shared types and helpers for the OTTER memory responder.
//   mem_size_t      - access size encoding carried on MEM_SIZE
//   p2_state_t      - port-2 transaction FSM states
//   IO_BASE_DEFAULT - first byte address of the memory-mapped IO window
//   access_legal()  - alignment/size legality check for port-2 accesses
package otter_mem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'd0,
    HALF    = 2'd1,
    WORD    = 2'd2,
    ILLEGAL = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } p2_state_t;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  // Halves need addr[0]=0, words need addr[1:0]=0, size 3 is never legal.
  function automatic logic access_legal(input mem_size_t size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      BYTE:    ok = 1'b1;
      HALF:    ok = ~addr_lo[0];
      WORD:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/otter_load_align.sv
// otter_load_align: combinational load lane extraction and extension.
//   addr_lo - byte offset within the word (addr[1:0])
//   size    - access size (byte/half/word; illegal yields 0)
//   sign    - 1 = zero-extend, 0 = sign-extend (ignored for words)
//   word    - raw 32-bit word from RAM or IO
//   data    - extended, LSB-aligned load result
module otter_load_align
  import otter_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_size_t   size,
  input  logic        sign,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half-word lanes.
  always_comb begin
    byte_s = 8'd0;
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend the selected lane to 32 bits.
  always_comb begin
    data = 32'd0;
    case (size)
      BYTE:    data = sign ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      HALF:    data = sign ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      WORD:    data = word;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/otter_mem_responder.sv
// otter_mem_responder: memory-side responder for the OTTER control FSM.
//   Port 1 (MEM_RDEN1/ADDR1 -> DOUT1/VALID1): single-cycle instruction fetch.
//   Port 2 (MEM_RDEN2/WE2/ADDR2/DIN2/SIZE/SIGN -> DOUT2/VALID2/BUSY2/ERR_MISALIGN):
//     data load/store with WAIT_CYC wait states, sizing and extension.
//   IO window (IO_WR/IO_ADDR/IO_OUT out, IO_IN in): addresses >= IO_BASE.
module otter_mem_responder
  import otter_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned WAIT_CYC    = 0,
  parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
`ifdef OTTER_MEM_INIT_EN
  ,
  parameter string       INIT_FILE   = "otter_memory.mem"
`endif
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        MEM_RDEN1,
  input  logic [31:0] MEM_ADDR1,
  output logic [31:0] MEM_DOUT1,
  output logic        MEM_VALID1,
  input  logic        MEM_RDEN2,
  input  logic        MEM_WE2,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_SIGN,
  output logic [31:0] MEM_DOUT2,
  output logic        MEM_VALID2,
  output logic        MEM_BUSY2,
  output logic        ERR_MISALIGN,
  output logic        IO_WR,
  output logic [31:0] IO_ADDR,
  output logic [31:0] IO_OUT,
  input  logic [31:0] IO_IN
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit          HAS_WAIT  = (WAIT_CYC != 0);
  localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYC - 1) : 4'd0;

  logic [31:0]      mem_r [DEPTH_WORDS];

  p2_state_t        state_r;
  logic [3:0]       cnt_r;
  logic [31:0]      pend_data_r;
  logic             pend_rd_r;
  logic             pend_err_r;

  logic [IDX_W-1:0] idx1_s;
  logic [IDX_W-1:0] idx2_s;
  logic             io1_s;
  logic             io2_s;
  mem_size_t        size2_s;
  logic             legal_s;
  logic             accept_s;
  logic             ram_we_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      load_s;
  logic [31:0]      rd_data_s;

  // Upper address bits above the RAM index are ignored, so accesses wrap.
  assign idx1_s    = MEM_ADDR1[IDX_W+1:2];
  assign idx2_s    = MEM_ADDR2[IDX_W+1:2];
  assign io1_s     = (MEM_ADDR1 >= IO_BASE);
  assign io2_s     = (MEM_ADDR2 >= IO_BASE);
  assign size2_s   = mem_size_t'(MEM_SIZE);
  assign legal_s   = access_legal(size2_s, MEM_ADDR2[1:0]);
  // Gating with RST_N keeps the RAM (which has no reset) from writing while reset is held.
  assign accept_s  = RST_N & (state_r == IDLE) & (MEM_RDEN2 | MEM_WE2);
  assign ram_we_s  = accept_s & MEM_WE2 & legal_s & ~io2_s;
  assign rd_word_s = io2_s ? IO_IN : mem_r[idx2_s];
  assign rd_data_s = legal_s ? load_s : 32'd0;

  otter_load_align u_align (
    .addr_lo (MEM_ADDR2[1:0]),
    .size    (size2_s),
    .sign    (MEM_SIGN),
    .word    (rd_word_s),
    .data    (load_s)
  );

  // Store lane enables and replicated write data.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = MEM_DIN2;
    case (size2_s)
      BYTE: begin
        be_s    = 4'b0001 << MEM_ADDR2[1:0];
        wdata_s = {4{MEM_DIN2[7:0]}};
      end
      HALF: begin
        be_s    = MEM_ADDR2[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{MEM_DIN2[15:0]}};
      end
      WORD:    be_s = 4'b1111;
      default: be_s = 4'b0000;
    endcase
  end

  // RAM byte-lane write, committed on the accept edge.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx2_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Port 1 fetch; a same-edge port-2 write is seen only on the next fetch.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      MEM_DOUT1  <= 32'd0;
      MEM_VALID1 <= 1'b0;
    end else begin
      MEM_VALID1 <= MEM_RDEN1;
      if (MEM_RDEN1) begin
        MEM_DOUT1 <= io1_s ? 32'd0 : mem_r[idx1_s];
      end
    end
  end

  // Port 2 transaction FSM; load data is captured at accept and released in RESP.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      pend_data_r  <= 32'd0;
      pend_rd_r    <= 1'b0;
      pend_err_r   <= 1'b0;
      MEM_DOUT2    <= 32'd0;
      MEM_VALID2   <= 1'b0;
      MEM_BUSY2    <= 1'b0;
      ERR_MISALIGN <= 1'b0;
      IO_WR        <= 1'b0;
      IO_ADDR      <= 32'd0;
      IO_OUT       <= 32'd0;
    end else begin
      MEM_VALID2   <= 1'b0;
      ERR_MISALIGN <= 1'b0;
      IO_WR        <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            MEM_BUSY2 <= 1'b1;
            if (MEM_WE2 && legal_s && io2_s) begin
              IO_WR   <= 1'b1;
              IO_ADDR <= MEM_ADDR2;
              IO_OUT  <= MEM_DIN2;
            end
            if (HAS_WAIT) begin
              state_r     <= WAIT;
              cnt_r       <= WAIT_LOAD;
              pend_data_r <= rd_data_s;
              pend_rd_r   <= ~MEM_WE2;
              pend_err_r  <= ~legal_s;
            end else begin
              state_r      <= RESP;
              MEM_VALID2   <= 1'b1;
              ERR_MISALIGN <= ~legal_s;
              if (!MEM_WE2) begin
                MEM_DOUT2 <= rd_data_s;
              end
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r      <= RESP;
            MEM_VALID2   <= 1'b1;
            ERR_MISALIGN <= pend_err_r;
            if (pend_rd_r) begin
              MEM_DOUT2 <= pend_data_r;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          state_r   <= IDLE;
          MEM_BUSY2 <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          MEM_BUSY2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_mem_responder.sv
// tb_otter_mem_responder: directed bench for otter_mem_responder.
// Two instances share all inputs: u_dut0 (no wait states) and u_dut3 (three).
module tb_otter_mem_responder;
  import otter_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rden1;
  logic [31:0] addr1;
  logic        rden2;
  logic        we2;
  logic [31:0] addr2;
  logic [31:0] din2;
  logic [1:0]  size2;
  logic        sign2;
  logic [31:0] io_in;

  logic [31:0] d0_dout1, d0_dout2, d0_io_addr, d0_io_out;
  logic        d0_valid1, d0_valid2, d0_busy2, d0_err, d0_io_wr;
  logic [31:0] d3_dout1, d3_dout2, d3_io_addr, d3_io_out;
  logic        d3_valid1, d3_valid2, d3_busy2, d3_err, d3_io_wr;

  int n_assert;
  int n_fail;

  otter_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .RST_N(rst_n),
    .MEM_RDEN1(rden1), .MEM_ADDR1(addr1), .MEM_DOUT1(d0_dout1), .MEM_VALID1(d0_valid1),
    .MEM_RDEN2(rden2), .MEM_WE2(we2), .MEM_ADDR2(addr2), .MEM_DIN2(din2),
    .MEM_SIZE(size2), .MEM_SIGN(sign2), .MEM_DOUT2(d0_dout2), .MEM_VALID2(d0_valid2),
    .MEM_BUSY2(d0_busy2), .ERR_MISALIGN(d0_err), .IO_WR(d0_io_wr),
    .IO_ADDR(d0_io_addr), .IO_OUT(d0_io_out), .IO_IN(io_in)
  );

  otter_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYC(3)) u_dut3 (
    .clk(clk), .RST_N(rst_n),
    .MEM_RDEN1(rden1), .MEM_ADDR1(addr1), .MEM_DOUT1(d3_dout1), .MEM_VALID1(d3_valid1),
    .MEM_RDEN2(rden2), .MEM_WE2(we2), .MEM_ADDR2(addr2), .MEM_DIN2(din2),
    .MEM_SIZE(size2), .MEM_SIGN(sign2), .MEM_DOUT2(d3_dout2), .MEM_VALID2(d3_valid2),
    .MEM_BUSY2(d3_busy2), .ERR_MISALIGN(d3_err), .IO_WR(d3_io_wr),
    .IO_ADDR(d3_io_addr), .IO_OUT(d3_io_out), .IO_IN(io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic p2_go(input logic we, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic sg);
    we2   = we;
    rden2 = rd;
    addr2 = a;
    din2  = d;
    size2 = sz;
    sign2 = sg;
    tick();
    we2   = 1'b0;
    rden2 = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    rden1 = 1'b1;
    addr1 = a;
    tick();
    rden1 = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    rden1 = 1'b0; addr1 = 32'd0;
    rden2 = 1'b0; we2 = 1'b0; addr2 = 32'd0; din2 = 32'd0;
    size2 = 2'd0; sign2 = 1'b0; io_in = 32'd0;

    // Reset state
    idle(2);
    chk("rst_dout1",  d0_dout1,  32'd0);
    chk("rst_valid1", {31'd0, d0_valid1}, 32'd0);
    chk("rst_dout2",  d0_dout2,  32'd0);
    chk("rst_valid2", {31'd0, d0_valid2}, 32'd0);
    chk("rst_busy2",  {31'd0, d0_busy2},  32'd0);
    chk("rst_err",    {31'd0, d0_err},    32'd0);
    chk("rst_io_wr",  {31'd0, d0_io_wr},  32'd0);
    chk("rst_io_out", d0_io_out, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Preload through port 2 with gaps long enough for both instances
    p2_go(1'b1, 1'b0, 32'h0000_0010, 32'h0050_0093, 2'd2, 1'b0); idle(6);
    p2_go(1'b1, 1'b0, 32'h0000_0100, 32'h1122_3344, 2'd2, 1'b0); idle(6);
    p2_go(1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 2'd2, 1'b0); idle(6);

    // Fetch: one-cycle VALID1 pulse, DOUT1 holds
    fetch(32'h0000_0010);
    chk("fetch_dout1",   d0_dout1, 32'h0050_0093);
    chk("fetch_valid1",  {31'd0, d0_valid1}, 32'd1);
    tick();
    chk("fetch_valid1_drop", {31'd0, d0_valid1}, 32'd0);
    chk("fetch_dout1_hold",  d0_dout1, 32'h0050_0093);

    // Byte store at 0x103 then signed/unsigned loads
    p2_go(1'b1, 1'b0, 32'h0000_0103, 32'h0000_0080, 2'd0, 1'b0);
    chk("sb_valid2", {31'd0, d0_valid2}, 32'd1);
    chk("sb_err",    {31'd0, d0_err},    32'd0);
    idle(2);
    fetch(32'h0000_0100);
    chk("sb_ram", d0_dout1, 32'h8022_3344);
    p2_go(1'b0, 1'b1, 32'h0000_0103, 32'd0, 2'd0, 1'b0);
    chk("lb_valid2", {31'd0, d0_valid2}, 32'd1);
    chk("lb_dout2",  d0_dout2, 32'hFFFF_FF80);
    tick();
    chk("lb_valid2_drop", {31'd0, d0_valid2}, 32'd0);
    chk("lb_dout2_hold",  d0_dout2, 32'hFFFF_FF80);
    idle(1);
    p2_go(1'b0, 1'b1, 32'h0000_0103, 32'd0, 2'd0, 1'b1);
    chk("lbu_dout2", d0_dout2, 32'h0000_0080);
    idle(2);
    p2_go(1'b0, 1'b1, 32'h0000_0102, 32'd0, 2'd1, 1'b0);
    chk("lh_dout2", d0_dout2, 32'hFFFF_8022);
    idle(2);
    p2_go(1'b1, 1'b0, 32'h0000_0100, 32'hABCD_5566, 2'd1, 1'b0);
    idle(2);
    fetch(32'h0000_0100);
    chk("sh_ram", d0_dout1, 32'h8022_5566);
    // Same-word fetch and store on one edge: fetch sees the old word
    rden1 = 1'b1;
    addr1 = 32'h0000_0100;
    p2_go(1'b1, 1'b0, 32'h0000_0100, 32'h0BAD_CAFE, 2'd2, 1'b0);
    rden1 = 1'b0;
    chk("collide_old", d0_dout1, 32'h8022_5566);
    idle(2);
    fetch(32'h0000_0100);
    chk("collide_new", d0_dout1, 32'h0BAD_CAFE);

    // Wait states on the WAIT_CYC=3 instance; strobe during busy is dropped
    idle(6);
    p2_go(1'b0, 1'b1, 32'h0000_0200, 32'd0, 2'd2, 1'b0);
    chk("w3_busy_a0",  {31'd0, d3_busy2},  32'd1);
    chk("w3_valid_a0", {31'd0, d3_valid2}, 32'd0);
    rden2 = 1'b1;
    tick();
    rden2 = 1'b0;
    chk("w3_busy_a1",  {31'd0, d3_busy2},  32'd1);
    chk("w3_valid_a1", {31'd0, d3_valid2}, 32'd0);
    tick();
    chk("w3_valid_a2", {31'd0, d3_valid2}, 32'd0);
    tick();
    chk("w3_valid_a3", {31'd0, d3_valid2}, 32'd1);
    chk("w3_busy_a3",  {31'd0, d3_busy2},  32'd1);
    chk("w3_dout2",    d3_dout2, 32'hCAFE_F00D);
    tick();
    chk("w3_valid_a4", {31'd0, d3_valid2}, 32'd0);
    chk("w3_busy_a4",  {31'd0, d3_busy2},  32'd0);
    tick();
    chk("w3_busy_a5",  {31'd0, d3_busy2},  32'd0);
    tick();
    chk("w3_valid_a6", {31'd0, d3_valid2}, 32'd0);

    // Misaligned word store and illegal size
    idle(1);
    p2_go(1'b1, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF, 2'd2, 1'b0);
    chk("mis_valid2", {31'd0, d0_valid2}, 32'd1);
    chk("mis_err",    {31'd0, d0_err},    32'd1);
    chk("mis_io_wr",  {31'd0, d0_io_wr},  32'd0);
    tick();
    chk("mis_err_drop", {31'd0, d0_err}, 32'd0);
    idle(1);
    fetch(32'h0000_0200);
    chk("mis_ram", d0_dout1, 32'hCAFE_F00D);
    p2_go(1'b0, 1'b1, 32'h0000_0200, 32'd0, 2'd3, 1'b0);
    chk("sz3_err",   {31'd0, d0_err},    32'd1);
    chk("sz3_valid", {31'd0, d0_valid2}, 32'd1);
    chk("sz3_dout2", d0_dout2, 32'd0);
    idle(2);

    // IO window write and read
    p2_go(1'b1, 1'b0, 32'h1100_0000, 32'h0000_1234, 2'd2, 1'b0);
    chk("io_wr",   {31'd0, d0_io_wr}, 32'd1);
    chk("io_out",  d0_io_out,  32'h0000_1234);
    chk("io_addr", d0_io_addr, 32'h1100_0000);
    tick();
    chk("io_wr_drop", {31'd0, d0_io_wr}, 32'd0);
    idle(1);
    io_in = 32'h0000_A5A5;
    p2_go(1'b0, 1'b1, 32'h1100_0000, 32'd0, 2'd2, 1'b0);
    chk("io_rd", d0_dout2, 32'h0000_A5A5);
    fetch(32'h1100_0004);
    chk("io_fetch_zero", d0_dout1, 32'd0);
    idle(2);

    // RDEN2 and WE2 together: write only, DOUT2 untouched
    p2_go(1'b1, 1'b1, 32'h0000_0300, 32'h5A5A_0001, 2'd2, 1'b0);
    chk("both_valid2", {31'd0, d0_valid2}, 32'd1);
    chk("both_dout2",  d0_dout2, 32'h0000_A5A5);
    idle(2);
    fetch(32'h0000_0300);
    chk("both_ram", d0_dout1, 32'h5A5A_0001);
    idle(6);

    // Reset in the middle of WAIT after a write was accepted
    p2_go(1'b1, 1'b0, 32'h0000_0304, 32'h7777_8888, 2'd2, 1'b0);
    tick();
    chk("rw_busy_pre", {31'd0, d3_busy2}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_busy_rst",  {31'd0, d3_busy2},  32'd0);
    chk("rw_dout2_rst", d3_dout2, 32'd0);
    chk("rw_dout1_rst", d3_dout1, 32'd0);
    idle(3);
    chk("rw_valid_rst", {31'd0, d3_valid2}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    chk("rw_valid_post", {31'd0, d3_valid2}, 32'd0);
    fetch(32'h0000_0304);
    chk("rw_ram_kept", d3_dout1, 32'h7777_8888);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_mem_responder.md
Name: otter_mem_responder

Overview:
Memory-side responder for the OTTER control FSM's strobes: services instruction fetch (port 1) and data load/store (port 2) against an internal word-array RAM and a memory-mapped IO window. Port 1 is fixed single-cycle latency. Port 2 runs a small FSM with programmable wait states, byte/half/word sizing and sign extension, and reports completion with valid pulses. Sits between the control unit/datapath and the bus, replacing the ideal combinational memory model.

Parameters:
DEPTH_WORDS, 16384, RAM size in 32-bit words (power of 2); word index = addr[log2(DEPTH)+1:2], upper bits ignored (wrap)
WAIT_CYC, 0, extra cycles port 2 stays busy before responding (0..15)
IO_BASE, 32'h1100_0000, addresses >= IO_BASE go to IO, not RAM

Ports:
clk  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
MEM_RDEN1  in  1  fetch strobe
MEM_ADDR1  in  32  fetch address (PC); addr[1:0] ignored
MEM_DOUT1  out  32  fetched instruction, registered
MEM_VALID1  out  1  one-cycle pulse: MEM_DOUT1 updated
MEM_RDEN2  in  1  data read strobe (may be held high continuously)
MEM_WE2  in  1  data write strobe
MEM_ADDR2  in  32  data byte address
MEM_DIN2  in  32  write data, LSB-aligned
MEM_SIZE  in  2  0 byte, 1 half, 2 word, 3 illegal
MEM_SIGN  in  1  1 = zero-extend loads (funct3[2]), 0 = sign-extend
MEM_DOUT2  out  32  load data, extended, registered
MEM_VALID2  out  1  one-cycle pulse: port-2 request complete
MEM_BUSY2  out  1  high while port 2 is in WAIT or RESP
ERR_MISALIGN  out  1  one-cycle pulse with MEM_VALID2 on a rejected access
IO_WR  out  1  one-cycle write strobe to IO
IO_ADDR  out  32  registered IO address
IO_OUT  out  32  registered IO write data
IO_IN  in  32  IO read data, sampled in the ACCEPT cycle

Behaviour:
- Reset (RST_N low, async): all outputs 0, FSM to IDLE. RAM contents not cleared. Reset mid-WAIT: response dropped; a write already committed remains committed.
- Port 1: RDEN1 high at edge N -> MEM_DOUT1 = RAM[idx] and MEM_VALID1 = 1 after edge N; VALID1 low otherwise, DOUT1 holds. Independent of port 2. IO addresses on port 1 return 0.
- Port 2 FSM states: IDLE, WAIT, RESP.
- IDLE: request = RDEN2 | WE2. WE2 wins if both high (no read performed). Accept on edge: alignment check (half: addr[0]=0; word: addr[1:0]=0; size 3 always illegal).
- Legal write: committed at the accept edge. RAM: byte lanes selected by size and addr[1:0], data replicated from DIN2 low bits. IO: IO_WR pulses, IO_ADDR/IO_OUT loaded, no RAM change.
- Legal read: RAM word or IO_IN captured at accept; lane extraction by addr[1:0]; extension per SIZE/SIGN; word ignores SIGN.
- Illegal access: no write, no IO_WR, load data 0, ERR_MISALIGN pulses with VALID2.
- Transitions: IDLE -> WAIT if WAIT_CYC>0, else IDLE -> RESP; WAIT counts WAIT_CYC cycles -> RESP; RESP: VALID2 = 1 and MEM_DOUT2 valid for one cycle -> IDLE. Total latency accept-to-VALID2 = WAIT_CYC+1 cycles.
- Requests while BUSY2 are ignored (not queued). RESP -> IDLE edge does not accept; next accept is the following edge.
- MEM_DOUT2 holds last load value until the next read completes; writes do not alter it.
- Port 1 and port 2 hitting the same word on one edge: port 1 returns the pre-write value.

Optional Feature:
OTTER_MEM_INIT_EN: defined -> RAM preloaded at elaboration via $readmemh from string parameter INIT_FILE (default "otter_memory.mem"). Undefined -> no initial block, INIT_FILE parameter absent, RAM contents undefined until written.

Decomposition:
- Package otter_mem_pkg: mem_size_t enum (BYTE, HALF, WORD, ILLEGAL), p2_state_t enum (IDLE, WAIT, RESP), IO_BASE default constant, alignment-check function.
- Sub-module otter_load_align: combinational lane extract + sign/zero extend (addr[1:0], size, sign, word -> 32-bit). No other sub-module.

Test Plan:
- Fetch: preload RAM[4]=32'h0050_0093; RDEN1=1, ADDR1=0x10 -> next cycle DOUT1=0x0050_0093, VALID1=1 for exactly one cycle.
- Byte store/load, WAIT_CYC=0: WE2, addr 0x103, size 0, DIN2=0x0000_0080 -> RAM[0x40] byte3=0x80, others unchanged; load signed byte 0x103 -> DOUT2=0xFFFF_FF80 one cycle after accept; unsigned -> 0x0000_0080.
- Wait states, WAIT_CYC=3: word read at 0x200 -> BUSY2 high 4 cycles, VALID2 at accept+4; second strobe during BUSY2 ignored (one VALID2 only).
- Misalign: word write at 0x202, DIN2=0xDEAD_BEEF -> ERR_MISALIGN with VALID2, RAM[0x80] unchanged, no IO_WR; size 3 at 0x200 -> same error.
- IO: WE2 at 0x1100_0000, DIN2=0x1234 -> IO_WR one cycle, IO_OUT=0x1234; read with IO_IN=0xA5A5 -> DOUT2=0x0000_A5A5.
- Reset: RST_N low mid-WAIT after write accept -> outputs 0 immediately, no VALID2; RAM word retains written value; both RDEN2 and WE2 high -> write only, DOUT2 unchanged.
